fetch_unit: RTL

//  Fetch stage plus IF/ID pipeline register; directly upstream of decode (immediate extender, control).

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Fetch stage and IF/ID pipeline register. Holds PC_F, addresses instruction memory and
// captures instruction/PC/PC+4 for decode, with a BOOT/RUN/HALT sequencer that traps misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_Stall_F,
  input  logic        i_Flush_D,
  input  logic        i_PC_Src_Sel,
  input  logic [31:0] i_PC_Target,
  input  logic [31:0] i_Instr_Rd,
  output logic [31:0] o_Instr_Addr,
  output logic [31:0] o_Instr_D,
  output logic [31:0] o_PC_D,
  output logic [31:0] o_PC_Plus_4_D,
  output logic        o_Valid_D,
  output logic        o_Fetch_Fault
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [31:0] r_pcF;
  logic [31:0] r_instrD;
  logic [31:0] r_pcD;
  logic [31:0] r_pcPlus4D;
  logic        r_validD;
  logic        r_fetchFault;

  logic [31:0] w_pcFNext;
  logic [31:0] w_instrDNext;
  logic [31:0] w_pcDNext;
  logic [31:0] w_pcPlus4DNext;
  logic        w_validDNext;
  logic        w_fetchFaultNext;

  logic [31:0] w_pcFPlus4;
  logic        w_misaligned;

  assign w_pcFPlus4   = r_pcF + 32'd4;
  assign w_misaligned = (i_PC_Target[1:0] != 2'b00);

  // Everything defaults to "hold"; a bubble only rewrites Instr_D and Valid_D,
  // so PC_D/PC_Plus_4_D keep describing the last real instruction.
  always_comb begin
    w_stateNext      = r_state;
    w_pcFNext        = r_pcF;
    w_instrDNext     = r_instrD;
    w_pcDNext        = r_pcD;
    w_pcPlus4DNext   = r_pcPlus4D;
    w_validDNext     = r_validD;
    w_fetchFaultNext = r_fetchFault;

    unique case (r_state)
      BOOT: begin
        w_instrDNext = NOP_INSTR;
        w_validDNext = 1'b0;
        w_stateNext  = RUN;
      end

      RUN: begin
        if (i_PC_Src_Sel && w_misaligned) begin
          w_stateNext      = HALT;
          w_fetchFaultNext = 1'b1;
          w_instrDNext     = NOP_INSTR;
          w_validDNext     = 1'b0;
        end else if (i_PC_Src_Sel) begin
          w_pcFNext    = i_PC_Target;
          w_instrDNext = NOP_INSTR;
          w_validDNext = 1'b0;
        end else if (i_Flush_D) begin
          w_instrDNext = NOP_INSTR;
          w_validDNext = 1'b0;
          if (!i_Stall_F) begin
            w_pcFNext = w_pcFPlus4;
          end
        end else if (!i_Stall_F) begin
          w_instrDNext   = i_Instr_Rd;
          w_pcDNext      = r_pcF;
          w_pcPlus4DNext = w_pcFPlus4;
          w_validDNext   = 1'b1;
          w_pcFNext      = w_pcFPlus4;
        end
      end

      HALT: begin
        w_instrDNext = NOP_INSTR;
        w_validDNext = 1'b0;
      end

      default: begin
        w_stateNext  = BOOT;
        w_instrDNext = NOP_INSTR;
        w_validDNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state      <= BOOT;
      r_pcF        <= RESET_PC;
      r_instrD     <= NOP_INSTR;
      r_pcD        <= 32'd0;
      r_pcPlus4D   <= 32'd0;
      r_validD     <= 1'b0;
      r_fetchFault <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_pcF        <= w_pcFNext;
      r_instrD     <= w_instrDNext;
      r_pcD        <= w_pcDNext;
      r_pcPlus4D   <= w_pcPlus4DNext;
      r_validD     <= w_validDNext;
      r_fetchFault <= w_fetchFaultNext;
    end
  end

  assign o_Instr_Addr  = r_pcF;
  assign o_Instr_D     = r_instrD;
  assign o_PC_D        = r_pcD;
  assign o_PC_Plus_4_D = r_pcPlus4D;
  assign o_Valid_D     = r_validD;
  assign o_Fetch_Fault = r_fetchFault;

endmodule
